// File: rtl/apb3_pkg.sv
// Shared definitions for the APB3 master bridge slice.
//   apb_state_e      : bridge FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   APB_DATA_WIDTH   : default APB data bus width
//   APB_TIMEOUT      : default ACCESS-cycle timeout (0 disables)
//   cnt_width()      : width needed for a counter that reaches a given value
package apb3_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // At least one bit, even when the timeout is disabled or trivially small.
    function automatic int cnt_width(input int max_value);
        int w;
        w = 1;
        while ((1 << w) <= max_value) w++;
        return w;
    endfunction

endpackage

// File: rtl/apb3_resp_mux.sv
// Combinational slave-response selector.
//   idx        : index of the currently selected slave
//   pready     : per-slave PREADY
//   prdata     : per-slave PRDATA, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
//   pslverr    : per-slave PSLVERR
//   sel_ready / sel_rdata / sel_slverr : response of slave idx only
module apb3_resp_mux #(
    parameter  int DATA_WIDTH = 32,
    parameter  int SEL_BITS   = 2,
    localparam int NUM_SLAVES = 2 ** SEL_BITS
) (
    input  logic [SEL_BITS-1:0]            idx,
    input  logic [NUM_SLAVES-1:0]          pready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]          pslverr,
    output logic                           sel_ready,
    output logic [DATA_WIDTH-1:0]          sel_rdata,
    output logic                           sel_slverr
);

    assign sel_ready  = pready[idx];
    assign sel_slverr = pslverr[idx];
    assign sel_rdata  = prdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/apb3_master_bridge.sv
// APB3 initiator: turns a valid/ready command into one SETUP + ACCESS APB3
// transfer and returns read data / error on a single-cycle response pulse.
//   io_apb_PCLK, io_apb_PRESET     : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command port (accepted when valid && ready)
//   rsp_valid/rdata/error          : one-cycle completion pulse, no backpressure
//   io_apb_P*                      : APB3 bus towards 2**SEL_BITS slaves; the
//                                    slave index is cmd_addr[ADDR_WIDTH-1 -: SEL_BITS]
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter  int ADDR_WIDTH = 12,
    parameter  int DATA_WIDTH = APB_DATA_WIDTH,
    parameter  int SEL_BITS   = 2,
    parameter  int TIMEOUT    = APB_TIMEOUT,
    localparam int NUM_SLAVES = 2 ** SEL_BITS
) (
    input  logic                             io_apb_PCLK,
    input  logic                             io_apb_PRESET,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_error,
    output logic [ADDR_WIDTH-1:0]            io_apb_PADDR,
    output logic [NUM_SLAVES-1:0]            io_apb_PSEL,
    output logic                             io_apb_PENABLE,
    output logic                             io_apb_PWRITE,
    output logic [DATA_WIDTH-1:0]            io_apb_PWDATA,
    input  logic [NUM_SLAVES-1:0]            io_apb_PREADY,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] io_apb_PRDATA,
    input  logic [NUM_SLAVES-1:0]            io_apb_PSLVERR
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    apb_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [SEL_BITS-1:0]     idx_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    error_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    sel_slverr;
    logic                    timed_out;

    apb3_resp_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_BITS   (SEL_BITS)
    ) u_resp_mux (
        .idx        (idx_q),
        .pready     (io_apb_PREADY),
        .prdata     (io_apb_PRDATA),
        .pslverr    (io_apb_PSLVERR),
        .sel_ready  (sel_ready),
        .sel_rdata  (sel_rdata),
        .sel_slverr (sel_slverr)
    );

    // cnt_q holds the number of ACCESS cycles already spent without PREADY,
    // so this fires on the TIMEOUT-th ACCESS cycle.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        io_apb_PSEL    = '0;
        io_apb_PENABLE = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                io_apb_PSEL = NUM_SLAVES'(1) << idx_q;
                state_d     = ST_ACCESS;
            end
            ST_ACCESS: begin
                io_apb_PSEL    = NUM_SLAVES'(1) << idx_q;
                io_apb_PENABLE = 1'b1;
                if (sel_ready || timed_out) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                wdata_q <= cmd_wdata;
                idx_q   <= cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
            end
            if (state_q == ST_ACCESS) begin
                if (sel_ready) begin
                    rdata_q <= (write_q || sel_slverr) ? '0 : sel_rdata;
                    error_q <= sel_slverr;
                end else if (timed_out) begin
                    rdata_q <= '0;
                    error_q <= 1'b1;
                end
            end
            if (state_q == ST_ACCESS && !sel_ready) cnt_q <= cnt_q + 1'b1;
            else                                    cnt_q <= '0;
        end
    end

    // Address/data lines come straight from the capture registers, so they
    // only change on command acceptance and hold their value otherwise.
    assign io_apb_PADDR  = addr_q;
    assign io_apb_PWRITE = write_q;
    assign io_apb_PWDATA = wdata_q;
    assign rsp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_error     = (state_q == ST_RESP) ? error_q : 1'b0;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed bench for apb3_master_bridge (TIMEOUT overridden to 4).
module tb_apb3_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr  = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_error;
    logic [AW-1:0]   paddr;
    logic [NS-1:0]   psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [NS-1:0]   pready;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]   pslverr;

    int checks = 0;
    int errors = 0;

    // Slave model: the slave the bench expects to be addressed answers after
    // model_waits wait states; all other slaves shout ready/error/junk.
    int          model_sel   = 0;
    int          model_waits = 0;
    logic [DW-1:0] model_rdata = '0;
    logic        model_err   = 1'b0;
    logic        bg_err      = 1'b1;
    int          acc_cnt     = 0;

    always #5 clk = ~clk;

    apb3_master_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SEL_BITS   (2),
        .TIMEOUT    (4)
    ) dut (
        .io_apb_PCLK    (clk),
        .io_apb_PRESET  (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .io_apb_PADDR   (paddr),
        .io_apb_PSEL    (psel),
        .io_apb_PENABLE (penable),
        .io_apb_PWRITE  (pwrite),
        .io_apb_PWDATA  (pwdata),
        .io_apb_PREADY  (pready),
        .io_apb_PRDATA  (prdata),
        .io_apb_PSLVERR (pslverr)
    );

    always @(posedge clk) acc_cnt <= penable ? acc_cnt + 1 : 0;

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int k = 0; k < NS; k++) begin
            if (k == model_sel) begin
                pready[k]            = (acc_cnt >= model_waits);
                pslverr[k]           = model_err;
                prdata[k*DW +: DW]   = model_rdata;
            end else begin
                pready[k]            = 1'b1;
                pslverr[k]           = bg_err;
                prdata[k*DW +: DW]   = 32'hDEAD_0000 | 32'(k);
            end
        end
    end

    // Bus protocol watch: at most one PSEL bit, PENABLE only with PSEL.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(psel) > 1 || (penable && psel == '0)) begin
                errors++;
                $display("FAIL protocol: psel=%b penable=%b required one-hot psel, penable only with psel", psel, penable);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] srdata;
        logic          serr;
        int            waits;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
        int            exp_acc;
    } vec_t;

    // Entered and left just after a falling edge with the bridge idle.
    task automatic run_vec(input vec_t v);
        int          lat;
        int          acc;
        bit          bad;
        logic [NS-1:0] epsel;
        epsel       = NS'(1) << v.addr[AW-1 -: 2];
        model_sel   = int'(v.addr[AW-1 -: 2]);
        model_waits = v.waits;
        model_rdata = v.srdata;
        model_err   = v.serr;
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge clk);
        // Scramble the command inputs: the bus must run from captured values.
        cmd_valid = 1'b0;
        cmd_write = ~v.wr;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        lat = 1;
        acc = 0;
        bad = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (lat == 1) begin
                if (psel !== epsel || penable !== 1'b0) bad = 1'b1;
            end else begin
                acc++;
                if (psel !== epsel || penable !== 1'b1) bad = 1'b1;
            end
            if (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency@%03h", v.addr), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("access_cycles@%03h", v.addr), 64'(acc), 64'(v.exp_acc));
        chk($sformatf("bus_phases@%03h", v.addr), 64'(bad), 64'd0);
        chk($sformatf("rsp_rdata@%03h", v.addr), 64'(rsp_rdata), 64'(v.exp_rdata));
        chk($sformatf("rsp_error@%03h", v.addr), 64'(rsp_error), 64'(v.exp_err));
        chk($sformatf("resp_psel@%03h", v.addr), 64'({psel, penable}), 64'd0);
        @(negedge clk);
        chk($sformatf("pulse_1cyc@%03h", v.addr), 64'(rsp_valid), 64'd0);
        chk($sformatf("ready_back@%03h", v.addr), 64'(cmd_ready), 64'd1);
    endtask

    vec_t vecs[7];

    logic [AW-1:0] b2b_addr[3];
    logic [DW-1:0] b2b_data[3];
    int            acc_cyc[3];

    initial begin
        // wr addr     wdata          srdata         serr waits exp_rdata      err lat acc
        vecs[0] = '{1'b1, 12'h010, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 0,   32'h0,         1'b0, 3, 1};
        vecs[1] = '{1'b0, 12'hC08, 32'h0,         32'h1234_5678, 1'b0, 3,   32'h1234_5678, 1'b0, 6, 4};
        vecs[2] = '{1'b0, 12'h404, 32'h0,         32'hCAFE_BABE, 1'b1, 0,   32'h0,         1'b1, 3, 1};
        vecs[3] = '{1'b0, 12'h8FC, 32'h0,         32'h1111_2222, 1'b0, 255, 32'h0,         1'b1, 6, 4};
        vecs[4] = '{1'b0, 12'h800, 32'h0,         32'h0BAD_F00D, 1'b0, 1,   32'h0BAD_F00D, 1'b0, 4, 2};
        vecs[5] = '{1'b1, 12'h7FF, 32'hA5A5_5A5A, 32'h3333_4444, 1'b1, 2,   32'h0,         1'b1, 5, 3};
        vecs[6] = '{1'b0, 12'h000, 32'h0,         32'h0000_55AA, 1'b0, 3,   32'h0000_55AA, 1'b0, 6, 4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_outputs", 64'({rsp_valid, rsp_error, psel, penable, pwrite}), 64'd0);
        chk("rst_data", 64'({rsp_rdata, paddr}), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back commands with cmd_valid held high
        b2b_addr = '{12'h104, 12'h508, 12'hD0C};
        b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        begin
            int  n;
            int  nrsp;
            bit  bad;
            bit  accepting;
            n = 0; nrsp = 0; bad = 1'b0;
            model_waits = 0;
            model_err   = 1'b0;
            bg_err      = 1'b0;
            cmd_valid   = 1'b1;
            cmd_write   = 1'b1;
            cmd_addr    = b2b_addr[0];
            cmd_wdata   = b2b_data[0];
            for (int cyc = 0; cyc < 40 && nrsp < 3; cyc++) begin
                if (psel != '0 && n > 0 && (paddr !== b2b_addr[n-1] || pwdata !== b2b_data[n-1])) bad = 1'b1;
                if (rsp_valid === 1'b1) begin
                    nrsp++;
                    if (rsp_error !== 1'b0) bad = 1'b1;
                end
                accepting = (cmd_valid && cmd_ready === 1'b1);
                if (accepting) acc_cyc[n] = cyc;
                @(posedge clk);
                #1;
                if (accepting) begin
                    n++;
                    if (n < 3) begin
                        cmd_addr  = b2b_addr[n];
                        cmd_wdata = b2b_data[n];
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
                @(negedge clk);
            end
            chk("b2b_accepted", 64'(n), 64'd3);
            chk("b2b_responses", 64'(nrsp), 64'd3);
            chk("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
            chk("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
            chk("b2b_paddr_stable", 64'(bad), 64'd0);
            bg_err = 1'b1;
        end

        // Reset during ACCESS
        begin
            bit saw_rsp;
            saw_rsp     = 1'b0;
            model_sel   = 2;
            model_waits = 255;
            cmd_valid   = 1'b1;
            cmd_write   = 1'b0;
            cmd_addr    = 12'h820;
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("pre_rst_access", 64'({psel, penable}), 64'b0100_1);
            #2 rst = 1'b1;
            #1;
            chk("async_rst_bus", 64'({psel, penable}), 64'd0);
            chk("async_rst_ready", 64'(cmd_ready), 64'd1);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (c == 1) rst = 1'b0;
                if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
            end
            chk("no_rsp_after_abort", 64'(saw_rsp), 64'd0);
        end

        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
